// File: rtl/ahb_regbank_slave.sv
// AHB-Lite register bank responder: NUM_REGS x 32-bit registers, programmable wait
// states before OKAY, and a two-cycle ERROR response for illegal transfers.
module ahb_regbank_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h0194_2001
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [31:0]              HRDATA,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [1:0]               state_o
);

  localparam int         RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WS4    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [RIDX_W-1:0]         idx_q, idx_d;
  logic                      write_q, write_d;
  logic [1:0]                size_q, size_d;
  logic [1:0]                lo_q, lo_d;
  logic                      hreadyout_q, hreadyout_d;
  logic [1:0]                hresp_q, hresp_d;
  logic [31:0]               hrdata_q, hrdata_d;
  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

  logic [ADDR_W-3:0] addr_idx;
  logic              illegal, complete, can_accept, accept;
  logic [3:0]        lane_en;
  logic              unused_htrans0;

  assign addr_idx       = HADDR[ADDR_W-1:2];
  assign unused_htrans0 = HTRANS[0];

  // Handshake: a transfer is accepted when HSEL, HTRANS[1] and HREADY are all high at a
  // rising edge; while HREADYOUT is low the current data phase is stretched and no
  // new address phase can be accepted.
  always_comb begin
    illegal    = (32'(addr_idx) >= 32'(NUM_REGS)) ||
                 (HSIZE > 3'b010) ||
                 ((HSIZE == 3'b001) && HADDR[0]) ||
                 ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) ||
                 (HWRITE && (addr_idx == '0));
    complete   = (state_q == DATA) && (cnt_q == 4'd0);
    can_accept = (state_q == IDLE) || complete || (state_q == ERR2);
    accept     = can_accept && HSEL && HTRANS[1] && HREADY;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    size_d  = size_q;
    lo_d    = lo_q;

    case (state_q)
      DATA:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      ERR1:    state_d = ERR2;
      default: ;
    endcase

    if (accept) begin
      idx_d   = addr_idx[RIDX_W-1:0];
      write_d = HWRITE;
      size_d  = HSIZE[1:0];
      lo_d    = HADDR[1:0];
      state_d = illegal ? ERR1 : DATA;
      cnt_d   = illegal ? 4'd0 : WS4;
    end else if (can_accept) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   lane_en = 4'b0001 << lo_q;
      2'b01:   lane_en = lo_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase

    regs_d = regs_q;
    if (complete && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) regs_d[idx_q][8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
    regs_d[0] = ID_VALUE;
  end

  // Outputs are registered from the next state; read data comes from regs_d so a
  // write completing at the same edge is forwarded to a pipelined read.
  always_comb begin
    hreadyout_d = !((state_d == ERR1) || ((state_d == DATA) && (cnt_d != 4'd0)));
    hresp_d     = ((state_d == ERR1) || (state_d == ERR2)) ? 2'b01 : 2'b00;
    hrdata_d    = ((state_d == DATA) && (cnt_d == 4'd0) && !write_d) ? regs_d[idx_d] : 32'h0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      lo_q        <= 2'b00;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= 32'h0;
      regs_q      <= '0;
      regs_q[0]   <= ID_VALUE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      regs_q      <= regs_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign regs_o    = regs_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ahb_regbank_slave.sv
// Bench for ahb_regbank_slave: two instances (WAIT_STATES=1 and 0) on one shared bus,
// a transfer-level response model with an expected-cycle queue, and directed vectors.
module tb_ahb_regbank_slave;

  localparam logic [31:0] ID = 32'h0194_2001;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- bus ----------------
  bit          sel;
  logic        hsel, hwrite;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic         ready1, ready0, hready;
  logic [1:0]   resp1, resp0, hresp;
  logic [31:0]  rd1, rd0, hrdata;
  logic [511:0] regs1, regs0;
  logic [1:0]   st1, st0;
  logic         hsel1, hsel0;

  assign hsel1  = hsel & sel;
  assign hsel0  = hsel & ~sel;
  assign hready = sel ? ready1 : ready0;
  assign hresp  = sel ? resp1 : resp0;
  assign hrdata = sel ? rd1 : rd0;

  ahb_regbank_slave #(.WAIT_STATES(1)) u_dut_ws1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ready1), .HRESP(resp1), .HRDATA(rd1), .regs_o(regs1), .state_o(st1)
  );

  ahb_regbank_slave #(.WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rd0), .regs_o(regs0), .state_o(st0)
  );

  // ---------------- model / scoreboard ----------------
  int          n_vec, n_miscmp;
  bit          chk_en;
  logic [31:0] mreg [2][16];
  logic [34:0] exp_q[$];   // {HREADYOUT, HRESP, HRDATA} per data-phase cycle
  logic [34:0] e;

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 16; r++) mreg[s][r] = (r == 0) ? ID : 32'h0;
    exp_q.delete();
  endtask

  function automatic void model_issue(bit w, logic [7:0] a, logic [2:0] sz, logic [31:0] wd);
    int idx, nbytes, ws, lane;
    bit bad;
    logic [31:0] rv;
    idx    = int'(a[7:2]);
    nbytes = 1 << sz;
    ws     = sel ? 1 : 0;
    bad    = (idx >= 16) || (sz > 3'd2) || ((int'(a[1:0]) % nbytes) != 0) || (w && idx == 0);
    if (bad) begin
      exp_q.push_back({1'b0, 2'b01, 32'h0});
      exp_q.push_back({1'b1, 2'b01, 32'h0});
      return;
    end
    rv = 32'h0;
    if (w) begin
      for (int b = 0; b < nbytes; b++) begin
        lane = int'(a[1:0]) + b;
        mreg[sel][idx][8*lane +: 8] = wd[8*lane +: 8];
      end
    end else begin
      rv = mreg[sel][idx];
    end
    for (int k = 0; k < ws; k++) exp_q.push_back({1'b0, 2'b00, 32'h0});
    exp_q.push_back({1'b1, 2'b00, rv});
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = {1'b1, 2'b00, 32'h0};
      n_vec++;
      if ({hready, hresp, hrdata} !== e) begin
        n_miscmp++;
        $display("FAIL bus_cycle t=%0t dut_ws=%0d: got rdy=%b resp=%b data=%h expected rdy=%b resp=%b data=%h",
                 $time, sel, hready, hresp, hrdata, e[34], e[33:32], e[31:0]);
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] get_reg(int r);
    return sel ? regs1[32*r +: 32] : regs0[32*r +: 32];
  endfunction

  task automatic check_regs(string tag);
    for (int r = 0; r < 16; r++) check($sformatf("%s_reg%0d", tag, r), get_reg(r), mreg[sel][r]);
  endtask

  // ---------------- driver ----------------
  int          nseq;
  bit          sq_w   [8];
  logic [7:0]  sq_a   [8];
  logic [2:0]  sq_sz  [8];
  logic [31:0] sq_wd  [8];
  logic [31:0] cap_rd [8];
  int          cap_cyc[8];

  task automatic add(bit w, logic [7:0] a, logic [2:0] sz, logic [31:0] wd);
    sq_w[nseq] = w; sq_a[nseq] = a; sq_sz[nseq] = sz; sq_wd[nseq] = wd;
    nseq++;
  endtask

  // Issues the queued transfers back-to-back (pipelined); starts and ends at posedge+1.
  task automatic run_seq();
    int cyc;
    logic r;
    logic [31:0] rd;
    for (int i = 0; i <= nseq; i++) begin
      if (i < nseq) begin
        hsel = 1'b1; htrans = 2'b10; hwrite = sq_w[i]; haddr = sq_a[i]; hsize = sq_sz[i];
      end else begin
        htrans = 2'b00; hwrite = 1'b0; haddr = 8'h0; hsize = 3'b000;
      end
      hwdata = (i > 0) ? sq_wd[i-1] : 32'h0;
      cyc = 0;
      do begin
        @(negedge clk);
        r  = hready;
        rd = hrdata;
        cyc++;
        @(posedge clk);
        #1;
      end while (!r && cyc < 40);
      if (!r) begin
        n_vec++; n_miscmp++;
        $display("FAIL timeout_hready: got ready=0 after %0d cycles expected ready=1", cyc);
      end
      if (i < nseq) model_issue(sq_w[i], sq_a[i], sq_sz[i], sq_wd[i]);
      if (i > 0) begin
        cap_rd[i-1]  = rd;
        cap_cyc[i-1] = cyc;
      end
    end
    hwdata = 32'h0;
    nseq   = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 8'h0;
    hsize = 3'b000; hwdata = 32'h0;
    n_vec = 0; n_miscmp = 0; chk_en = 1'b0; nseq = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", {31'h0, hready}, 32'h1);
    check("reset_id", get_reg(0), ID);
    check_regs("reset");

    // word write then read, one wait state
    add(1'b1, 8'h08, 3'b010, 32'hDEAD_BEEF); run_seq();
    check("wr08_cycles", 32'(cap_cyc[0]), 32'd2);
    add(1'b0, 8'h08, 3'b010, 32'h0); run_seq();
    check("rd08_data", cap_rd[0], 32'hDEAD_BEEF);
    check("regs_95_64", regs1[95:64], 32'hDEAD_BEEF);

    // ID register: readable, write is an ERROR and changes nothing
    add(1'b0, 8'h00, 3'b010, 32'h0); run_seq();
    check("rd00_id", cap_rd[0], ID);
    add(1'b1, 8'h00, 3'b010, 32'h1234_5678); run_seq();
    check("wr00_err_cycles", 32'(cap_cyc[0]), 32'd2);
    check("reg0_kept", regs1[31:0], ID);
    check_regs("id");

    // illegal transfers, pipelined behind each other
    add(1'b0, 8'h40, 3'b010, 32'h0);
    add(1'b1, 8'h05, 3'b001, 32'hFFFF_FFFF);
    add(1'b0, 8'h10, 3'b011, 32'h0);
    add(1'b1, 8'h40, 3'b010, 32'h0000_CAFE);
    run_seq();
    for (int k = 0; k < 4; k++) check($sformatf("err%0d_cycles", k), 32'(cap_cyc[k]), 32'd2);
    check_regs("illegal");

    // byte lanes
    add(1'b1, 8'h0C, 3'b010, 32'h1122_3344);
    add(1'b1, 8'h0D, 3'b000, 32'h0000_AA00);
    add(1'b0, 8'h0C, 3'b010, 32'h0);
    run_seq();
    check("rd0c_byte", cap_rd[2], 32'h1122_AA44);
    check("regs_127_96", regs1[127:96], 32'h1122_AA44);
    add(1'b1, 8'h0E, 3'b001, 32'hBEEF_0000);
    add(1'b0, 8'h0C, 3'b010, 32'h0);
    add(1'b1, 8'h2F, 3'b000, 32'h5A00_0000);
    add(1'b0, 8'h2C, 3'b010, 32'h0);
    add(1'b0, 8'h0E, 3'b001, 32'h0);
    run_seq();
    check("rd0c_half", cap_rd[1], 32'hBEEF_AA44);
    check("rd2c_byte3", cap_rd[3], 32'h5A00_0000);
    check("rd0e_half", cap_rd[4], 32'hBEEF_AA44);
    check_regs("lanes");

    // zero wait states: pipelined write then read of the same register
    sel = 1'b0;
    add(1'b1, 8'h10, 3'b010, 32'h0000_0005);
    add(1'b0, 8'h10, 3'b010, 32'h0);
    run_seq();
    check("ws0_rd10", cap_rd[1], 32'h0000_0005);
    check("ws0_wr_cycles", 32'(cap_cyc[0]), 32'd1);
    check("ws0_rd_cycles", 32'(cap_cyc[1]), 32'd1);
    add(1'b0, 8'h03, 3'b010, 32'h0);
    add(1'b0, 8'h10, 3'b010, 32'h0);
    add(1'b1, 8'h3C, 3'b010, 32'h0000_0099);
    run_seq();
    check("ws0_err_cycles", 32'(cap_cyc[0]), 32'd2);
    check("ws0_rd_after_err", cap_rd[1], 32'h0000_0005);
    check_regs("ws0");

    // reset during the wait cycle of a write
    sel = 1'b1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h04; hsize = 3'b010;
    @(posedge clk); #1;
    model_issue(1'b1, 8'h04, 3'b010, 32'h0000_0077);
    htrans = 2'b00; hwrite = 1'b0; haddr = 8'h0; hsize = 3'b000; hwdata = 32'h0000_0077;
    @(negedge clk); #1;
    check("rst_wait_ready", {31'h0, hready}, 32'h0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_ready", {31'h0, hready}, 32'h1);
    check("rst_async_resp", {30'h0, hresp}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1; hwdata = 32'h0;
    @(posedge clk); #1;
    check("rst_reg1", get_reg(1), 32'h0);
    check_regs("post_rst");

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
